// File: rtl/io_reg_arbiter.sv
// io_reg_arbiter: round-robin two-master arbiter and three-phase sequencer
// for a bank of 32-bit IO registers. Each transaction runs IDLE -> ACCESS -> RESP.
// The bank strobes are asserted for the single ACCESS cycle.
// The winning master then gets read data, an error flag and a one-cycle ack in RESP.
module io_reg_arbiter #(
    parameter int unsigned N_REGS = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     m0_req_i,
    input  logic                     m0_we_i,
    input  logic [ADDR_W-1:0]        m0_addr_i,
    input  logic [31:0]              m0_wdata_i,
    output logic                     m0_gnt_o,
    output logic                     m0_ack_o,

    input  logic                     m1_req_i,
    input  logic                     m1_we_i,
    input  logic [ADDR_W-1:0]        m1_addr_i,
    input  logic [31:0]              m1_wdata_i,
    output logic                     m1_gnt_o,
    output logic                     m1_ack_o,

    output logic [31:0]              rdata_o,
    output logic                     err_o,

    output logic [N_REGS-1:0]        sel_o,
    output logic                     rd_o,
    output logic                     wr_o,
    output logic [31:0]              data_o,
    input  logic [32*N_REGS-1:0]     bank_rdata_i
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q;
    logic                owner_q;
    logic                last_owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                any_req;
    logic                win;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                in_range;
    logic [DATA_W-1:0]   bank_word;
    logic [N_REGS-1:0]   sel_dec;
    logic                in_access;
    logic                in_resp;

    assign any_req = m0_req_i | m1_req_i;

    // Round-robin pick: a lone requester wins, on contention the master that did not go last wins
    always_comb begin
        win = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            win = ~last_owner_q;
        end
    end

    // Attributes of the winning master, captured only on the IDLE -> ACCESS edge
    always_comb begin
        win_we    = win ? m1_we_i    : m0_we_i;
        win_addr  = win ? m1_addr_i  : m0_addr_i;
        win_wdata = win ? m1_wdata_i : m0_wdata_i;
    end

    assign in_range = (32'(addr_q) < N_REGS);

    // Slice the addressed register out of the concatenated bank read bus
    always_comb begin
        bank_word = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            if (addr_q == ADDR_W'(k)) begin
                bank_word = bank_rdata_i[DATA_W*k +: DATA_W];
            end
        end
    end

    // One-hot select; an out-of-range address matches no register and stays all zero
    always_comb begin
        sel_dec = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            sel_dec[k] = (addr_q == ADDR_W'(k));
        end
    end

    // Sequencer: latch the winner in IDLE, capture the response at the end of ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q      <= win;
                        last_owner_q <= win;
                        we_q         <= win_we;
                        addr_q       <= win_addr;
                        wdata_q      <= win_wdata;
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= (in_range && !we_q) ? bank_word : '0;
                    err_q   <= ~in_range;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

    // Bank strobes decode straight off the state register so a reset drops them immediately
    always_comb begin
        sel_o  = in_access ? sel_dec : '0;
        wr_o   = in_access &&  we_q && in_range;
        rd_o   = in_access && !we_q && in_range;
        data_o = in_access ? wdata_q : '0;
    end

    // Grant spans ACCESS and RESP; ack and response data are visible in RESP only
    always_comb begin
        m0_gnt_o = (state_q != ST_IDLE) && !owner_q;
        m1_gnt_o = (state_q != ST_IDLE) &&  owner_q;
        m0_ack_o = in_resp && !owner_q;
        m1_ack_o = in_resp &&  owner_q;
        rdata_o  = in_resp ? rdata_q : '0;
        err_o    = in_resp && err_q;
    end

endmodule

// File: tb/tb_io_reg_arbiter.sv
// tb_io_reg_arbiter: scoreboard bench for io_reg_arbiter with a behavioural register bank.
module tb_io_reg_arbiter;

    localparam int unsigned N_REGS = 4;
    localparam int unsigned ADDR_W = 4;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [ADDR_W-1:0]    m0_addr_i, m1_addr_i;
    logic [31:0]          m0_wdata_i, m1_wdata_i;
    logic                 m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o;
    logic [31:0]          rdata_o;
    logic                 err_o;
    logic [N_REGS-1:0]    sel_o;
    logic                 rd_o, wr_o;
    logic [31:0]          data_o;
    logic [32*N_REGS-1:0] bank_rdata_i;

    io_reg_arbiter #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m0_req_i     (m0_req_i),
        .m0_we_i      (m0_we_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_ack_o     (m0_ack_o),
        .m1_req_i     (m1_req_i),
        .m1_we_i      (m1_we_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_ack_o     (m1_ack_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .sel_o        (sel_o),
        .rd_o         (rd_o),
        .wr_o         (wr_o),
        .data_o       (data_o),
        .bank_rdata_i (bank_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural register bank driven by the DUT strobes
    logic [31:0] bank [N_REGS];
    logic        bank_clr;

    always @(posedge clk_i) begin
        if (bank_clr) begin
            for (int k = 0; k < N_REGS; k++) bank[k] <= 32'h0;
        end else if (wr_o) begin
            for (int k = 0; k < N_REGS; k++) if (sel_o[k]) bank[k] <= data_o;
        end
    end

    assign bank_rdata_i = {bank[3], bank[2], bank[1], bank[0]};

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
    } strb_t;

    resp_t       sb_q[$];
    strb_t       strb_q[$];
    int          ack_cyc[$];
    logic [31:0] shadow [N_REGS];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int both_gnt = 0;
    int both_ack = 0;
    int junk = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, want);
        end
    endtask

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [3:0] addr, input logic [31:0] wd);
        if (!m) begin
            m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wd;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wd;
        end
    endtask

    // Predict response and bank strobe of one transaction, in grant order
    task automatic expect_txn(input logic m, input logic we, input logic [3:0] addr,
                              input logic [31:0] wd);
        logic  in_rng;
        resp_t r;
        strb_t s;
        in_rng  = (addr < 4'(N_REGS));
        r.m     = m;
        r.err   = !in_rng;
        r.rdata = (in_rng && !we) ? shadow[addr[1:0]] : 32'h0;
        sb_q.push_back(r);
        if (in_rng) begin
            s.sel  = 4'(1) << addr;
            s.we   = we;
            s.data = wd;
            strb_q.push_back(s);
            if (we) shadow[addr[1:0]] = wd;
        end
    endtask

    // Single transaction from one master; returns negedges from request to ack
    task automatic txn(input logic m, input logic we, input logic [3:0] addr,
                       input logic [31:0] wd, output int lat);
        logic acked;
        acked = 1'b0;
        lat   = 0;
        expect_txn(m, we, addr, wd);
        drive(m, 1'b1, we, addr, wd);
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clk_i);
            lat++;
            acked = m ? m1_ack_o : m0_ack_o;
        end
        check("txn_ack_seen", 64'(acked), 64'd1);
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    // Output monitor: pops strobe and response expectations as the DUT produces them
    always @(negedge clk_i) begin
        resp_t r;
        strb_t s;
        cyc++;
        if (rst_ni) begin
            if (m0_gnt_o && m1_gnt_o) both_gnt++;
            if (m0_ack_o && m1_ack_o) both_ack++;
            if (rd_o || wr_o) begin
                if (strb_q.size() == 0) begin
                    check("strobe_underflow", 64'(strb_q.size()), 64'd1);
                end else begin
                    s = strb_q.pop_front();
                    check("strobe_sel",  64'(sel_o),  64'(s.sel));
                    check("strobe_wr",   64'(wr_o),   64'(s.we));
                    check("strobe_rd",   64'(rd_o),   64'(!s.we));
                    check("strobe_data", 64'(data_o), 64'(s.data));
                end
            end
            if (m0_ack_o || m1_ack_o) begin
                ack_cyc.push_back(cyc);
                if ((sel_o != '0) || rd_o || wr_o || (data_o != 32'h0)) junk++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    r = sb_q.pop_front();
                    check("ack_master", 64'(m1_ack_o), 64'(r.m));
                    check("ack_rdata",  64'(rdata_o),  64'(r.rdata));
                    check("ack_err",    64'(err_o),    64'(r.err));
                end
            end else if ((rdata_o != 32'h0) || err_o) begin
                junk++;
            end
            if (!(m0_gnt_o || m1_gnt_o) && ((data_o != 32'h0) || (sel_o != '0) || rd_o || wr_o)) junk++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   first;
        int   n0;
        int   n1;
        logic done0;
        logic done1;

        for (int k = 0; k < N_REGS; k++) shadow[k] = 32'h0;
        rst_ni   = 1'b0;
        bank_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        repeat (2) @(negedge clk_i);

        check("reset_ctrl", 64'({m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, err_o, sel_o, rd_o, wr_o}), 64'd0);
        check("reset_data", {rdata_o, data_o}, 64'd0);
        rst_ni   = 1'b1;
        bank_clr = 1'b0;
        @(negedge clk_i);

        // Write then read back, first one also checks ack latency
        txn(1'b0, 1'b1, 4'd2, 32'hDEADBEEF, lat);
        check("write_ack_latency", 64'(lat), 64'd2);
        @(negedge clk_i);
        txn(1'b0, 1'b0, 4'd2, 32'h0, lat);
        check("read_ack_latency", 64'(lat), 64'd2);

        // Out-of-range read and write: ack with err, no strobes
        txn(1'b1, 1'b0, 4'd5, 32'h0, lat);
        txn(1'b1, 1'b1, 4'd7, 32'h55AA55AA, lat);
        // Leave last_owner at 0 so m1 would win a tie if reset were ignored
        txn(1'b0, 1'b1, 4'd3, 32'h11111111, lat);

        // Reset in the middle of ACCESS of a write
        @(negedge clk_i);
        drive(1'b0, 1'b1, 1'b1, 4'd3, 32'h12345678);
        @(posedge clk_i);
        #2;
        check("abort_wr_active", 64'(wr_o), 64'd1);
        check("abort_sel_active", 64'(sel_o), 64'b1000);
        rst_ni = 1'b0;
        #1;
        check("abort_ctrl_zero", 64'({m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, err_o, sel_o, rd_o, wr_o}), 64'd0);
        check("abort_data_zero", {rdata_o, data_o}, 64'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        check("abort_no_ack", 64'({m0_ack_o, m1_ack_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Simultaneous request after reset: m0 wins; aborted write must not be visible
        expect_txn(1'b0, 1'b0, 4'd3, 32'h0);
        expect_txn(1'b1, 1'b1, 4'd0, 32'hCAFEF00D);
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 4'd0, 32'hCAFEF00D);
        first = 2;
        done0 = 1'b0;
        done1 = 1'b0;
        for (int i = 0; i < 20 && !(done0 && done1); i++) begin
            @(negedge clk_i);
            if (m0_ack_o) begin
                done0 = 1'b1;
                drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
                if (first == 2) first = 0;
            end
            if (m1_ack_o) begin
                done1 = 1'b1;
                drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
                if (first == 2) first = 1;
            end
        end
        check("post_reset_first_winner", 64'(first), 64'd0);
        check("post_reset_both_done", 64'({done0, done1}), 64'b11);
        @(negedge clk_i);

        // Continuous contention: grants alternate m0, m1, ...
        for (int i = 0; i < 3; i++) begin
            expect_txn(1'b0, 1'b1, 4'd1, 32'h1000_0000 + 32'(i));
            expect_txn(1'b1, 1'b1, 4'd2, 32'h2000_0000 + 32'(i));
        end
        ack_cyc.delete();
        n0 = 0;
        n1 = 0;
        drive(1'b0, 1'b1, 1'b1, 4'd1, 32'h1000_0000);
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h2000_0000);
        for (int i = 0; i < 40 && (n0 < 3 || n1 < 3); i++) begin
            @(negedge clk_i);
            if (m0_ack_o) begin
                n0++;
                if (n0 < 3) drive(1'b0, 1'b1, 1'b1, 4'd1, 32'h1000_0000 + 32'(n0));
                else        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
            end
            if (m1_ack_o) begin
                n1++;
                if (n1 < 3) drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h2000_0000 + 32'(n1));
                else        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
            end
        end
        @(negedge clk_i);
        check("contention_acks", 64'({n0[7:0], n1[7:0]}), 64'h0303);
        check("contention_ack_count", 64'(ack_cyc.size()), 64'd6);
        for (int k = 1; k < ack_cyc.size(); k++) begin
            check("contention_ack_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd3);
        end
        txn(1'b1, 1'b0, 4'd1, 32'h0, lat);
        txn(1'b0, 1'b0, 4'd2, 32'h0, lat);
        txn(1'b1, 1'b0, 4'd0, 32'h0, lat);
        @(negedge clk_i);

        // Attributes changed during ACCESS are ignored; held req is regranted after RESP
        expect_txn(1'b0, 1'b1, 4'd1, 32'hAAAA5555);
        drive(1'b0, 1'b1, 1'b1, 4'd1, 32'hAAAA5555);
        @(negedge clk_i);
        check("stab_gnt_access", 64'(m0_gnt_o), 64'd1);
        drive(1'b0, 1'b1, 1'b1, 4'd2, 32'h0BAD0BAD);
        expect_txn(1'b0, 1'b1, 4'd2, 32'h0BAD0BAD);
        @(negedge clk_i);
        check("stab_ack", 64'(m0_ack_o), 64'd1);
        @(negedge clk_i);
        check("stab_idle_gnt", 64'(m0_gnt_o), 64'd0);
        @(negedge clk_i);
        check("stab_regrant", 64'(m0_gnt_o), 64'd1);
        @(negedge clk_i);
        check("stab_ack2", 64'(m0_ack_o), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        txn(1'b0, 1'b0, 4'd1, 32'h0, lat);
        txn(1'b0, 1'b0, 4'd2, 32'h0, lat);

        repeat (4) @(negedge clk_i);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("strobes_drained", 64'(strb_q.size()), 64'd0);
        check("never_both_gnt", 64'(both_gnt), 64'd0);
        check("never_both_ack", 64'(both_ack), 64'd0);
        check("quiet_outside_phase", 64'(junk), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_reg_arbiter.md
# io_reg_arbiter

Two-master arbiter and sequencer for the bank of 32-bit IO registers in the IO interface. It shares the register bank between the core's load/store port (master 0) and a secondary bus master (master 1). It decodes the word address into one-hot register selects and drives the bank's sel/rd/wr/data strobes for exactly one cycle per transaction. It returns read data and a single-cycle acknowledge to the winning master.

## Interface
- N_REGS, 4: number of IO registers in the bank (2..16).
- ADDR_W, 4: address width. Addresses ≥ N_REGS are out of range.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- m0_req_i, m1_req_i  input  1  transaction request; held high until the matching ack.
- m0_we_i, m1_we_i  input  1  1 = write, 0 = read.
- m0_addr_i, m1_addr_i  input  ADDR_W  register index.
- m0_wdata_i, m1_wdata_i  input  32  write data.
- m0_gnt_o, m1_gnt_o  output  1  master owns the bank (ACCESS and RESP states).
- m0_ack_o, m1_ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  read data; valid only while an ack is high.
- err_o  output  1  out-of-range address; valid only while an ack is high.
- sel_o  output  N_REGS  one-hot register select to the bank.
- rd_o, wr_o  output  1  read/write strobes to the bank.
- data_o  output  32  write data to the bank.
- bank_rdata_i  input  32*N_REGS  concatenated register outputs; register k sits at bits [32k+31:32k].

## Operation
- FSM states:
  - IDLE: if any req is high, latch the winner's we, addr and wdata, set owner, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: always go to RESP.
  - RESP: always go to IDLE.
- Arbitration is round-robin and uses last_owner (reset value 1, so master 0 wins first).
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not last_owner wins.
  - last_owner updates to the winner on the IDLE→ACCESS edge.
- Request inputs and their attributes are sampled only in IDLE. Changes during ACCESS and RESP are ignored.
- ACCESS drives the bank:
  - sel_o = one-hot(addr) if addr < N_REGS, else all zeros.
  - wr_o = we; rd_o = !we; data_o = latched wdata.
  - sel/rd/wr are decoded combinationally from state and latched registers. They must be 0 in every state other than ACCESS.
  - data_o is 0 outside ACCESS.
- At the end of ACCESS:
  - Read: rdata register ← bank_rdata_i slice[addr].
  - Write, or out-of-range address: rdata register ← 0.
  - err register ← (addr ≥ N_REGS).
- RESP behaviour:
  - owner's ack_o = 1; rdata_o and err_o are presented.
  - Outside RESP, rdata_o = 0 and err_o = 0.
- gnt_o of the owner is high in ACCESS and RESP. Both gnt_o are 0 in IDLE.
- An out-of-range transaction still completes and acks; no bank strobe is asserted.
- A master that keeps req high through its ack is treated as a new request in the following IDLE. It is still subject to round-robin.

## Timing
- Reset values: state IDLE, last_owner 1, all latches 0, every output 0.
- Reset asserted mid-transaction aborts immediately:
  - No ack is issued.
  - A write strobe still inside ACCESS is removed asynchronously.
  - The bank's own capture edge then depends on the bank's reset.
- Req seen high at rising edge T (state IDLE):
  - ACCESS occupies cycle T..T+1. The bank captures the write at edge T+1.
  - RESP/ack occupies cycle T+1..T+2.
  - FSM is back in IDLE after edge T+2, so the next grant is at edge T+3 at the earliest.
- Throughput: one transaction per 3 cycles; at most one ack high per cycle.
- Write-then-read of the same register by the same master returns the new value. The write is captured at the end of ACCESS, before the read's ACCESS begins.

## Test plan
- **Reset:** drive rst_ni low mid-ACCESS → all outputs 0 within the same cycle; after release, state is IDLE and master 0 wins a simultaneous request.
- **Single write/read (N_REGS=4):**
  - m0 writes 0xDEADBEEF to addr 2 → sel_o=4'b0100 and wr_o=1 for exactly one cycle; m0_ack_o pulses 2 cycles after the request is sampled.
  - m0 then reads addr 2 → rdata_o=0xDEADBEEF during ack, err_o=0.
- **Contention:** m0 and m1 hold req continuously, each writing a distinct address → grants alternate m0, m1, m0, m1; acks are spaced 3 cycles apart; no cycle has both gnt_o high.
- **Out of range:** m1 reads addr 5 with N_REGS=4 → sel_o, rd_o and wr_o stay 0; m1_ack_o=1 with err_o=1 and rdata_o=0.
- **Attribute stability:** m0 changes addr and wdata during ACCESS → the bank sees only the values sampled in IDLE; the next request is not granted until after RESP.
